// File: rtl/seq_code_monitor.sv
// -----------------------------------------------------------------------------
// seq_code_monitor
//
// Receive-side integrity monitor for the 5-state code sequence
//   000 -> 100 -> 111 -> 010 -> 011 -> 000
// produced by the companion FSM counter. The counter updates on the falling
// edge of the shared clock, and this block samples code_in on the rising edge
// half a cycle later.
//
// The monitor hunts for LOCK_N consecutive correct transitions and then locks.
// While locked it decodes each code to its position, flags out-of-order codes
// on err_pulse, flags illegal codes on illegal_pulse, and counts completed
// periods (011 -> 000 while locked) on wrap_pulse / wrap_count.
//
// Parameters
//   LOCK_N  : consecutive correct transitions needed to lock (1..7)
//   ERR_W   : width of the saturating violation counter
//   WRAP_W  : width of the period counter (wraps modulo 2^WRAP_W)
//
// Ports
//   clk           in   sampling clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   code_valid    in   code_in is sampled on this edge
//   code_in       in   [2:0] code from the counter
//   index         out  [2:0] decoded position 0..4
//   index_valid   out  index is trustworthy (equals locked)
//   locked        out  monitor is locked to the sequence
//   err_pulse     out  one-cycle flag, sequence violation while locked
//   illegal_pulse out  one-cycle flag, illegal code in any state
//   wrap_pulse    out  one-cycle flag, completed period while locked
//   err_count     out  [ERR_W-1:0] saturating violation count
//   wrap_count    out  [WRAP_W-1:0] period count
//
// Build option
//   SEQ_MON_RESYNC_EN : when defined, a legal out-of-order code while locked
//                       re-aligns index to the received code and stays locked.
//                       When undefined, it drops back to HUNT and must relock.
//                       Illegal codes return to HUNT in both builds.
// -----------------------------------------------------------------------------
module seq_code_monitor #(
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [2:0]        code_in,
  output logic [2:0]        index,
  output logic              index_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic              illegal_pulse,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [2:0]        LOCK_TARGET = 3'(LOCK_N);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE     = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE    = WRAP_W'(1);

  // ---------------------------------------------------------------------------
  // Registered state and its next-state values
  // ---------------------------------------------------------------------------
  state_t            state_q,       state_d;
  logic [2:0]        prev_idx_q,    prev_idx_d;
  logic              prev_ok_q,     prev_ok_d;
  logic [2:0]        match_cnt_q,   match_cnt_d;
  logic [2:0]        index_q,       index_d;
  logic              err_q,         err_d;
  logic              illegal_q,     illegal_d;
  logic              wrap_q,        wrap_d;
  logic [ERR_W-1:0]  err_count_q,   err_count_d;
  logic [WRAP_W-1:0] wrap_count_q,  wrap_count_d;

  // Decoded view of the current sample
  logic [2:0] dec_idx;
  logic       dec_legal;

  // Position that follows p in the 5-state cycle.
  function automatic logic [2:0] next_pos(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Code decoder: the counter's codes are not binary-ordered, so map each to
  // its position. Codes 001, 101 and 110 never appear in a healthy sequence.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_idx   = 3'd0;
    dec_legal = 1'b1;
    case (code_in)
      3'b000:  dec_idx = 3'd0;
      3'b100:  dec_idx = 3'd1;
      3'b111:  dec_idx = 3'd2;
      3'b010:  dec_idx = 3'd3;
      3'b011:  dec_idx = 3'd4;
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    prev_idx_d   = prev_idx_q;
    prev_ok_d    = prev_ok_q;
    match_cnt_d  = match_cnt_q;
    index_d      = index_q;
    err_d        = 1'b0;
    illegal_d    = 1'b0;
    wrap_d       = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    // A gap in code_valid freezes everything; pulses fall to zero by default.
    if (code_valid) begin
      unique case (state_q)
        HUNT: begin
          if (!dec_legal) begin
            illegal_d   = 1'b1;
            prev_ok_d   = 1'b0;
            match_cnt_d = 3'd0;
          end else begin
            prev_idx_d = dec_idx;
            prev_ok_d  = 1'b1;
            if (prev_ok_q && (dec_idx == next_pos(prev_idx_q))) begin
              match_cnt_d = match_cnt_q + 3'd1;
              // match_cnt never exceeds LOCK_N-1 while hunting, so the
              // increment cannot overflow for any legal LOCK_N.
              if (match_cnt_d == LOCK_TARGET) begin
                state_d = LOCKED;
                index_d = dec_idx;
              end
            end else begin
              match_cnt_d = 3'd0;
            end
          end
        end

        LOCKED: begin
          if (dec_legal && (dec_idx == next_pos(index_q))) begin
            index_d = dec_idx;
            if (dec_idx == 3'd0) begin
              wrap_d       = 1'b1;
              wrap_count_d = wrap_count_q + WRAP_ONE;
            end
          end else begin
            // Includes a repeated code: the counter advances every cycle, so
            // seeing the same position twice is itself a fault.
            err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_ONE;
            end

            if (!dec_legal) begin
              illegal_d   = 1'b1;
              state_d     = HUNT;
              prev_ok_d   = 1'b0;
              match_cnt_d = 3'd0;
            end else begin
`ifdef SEQ_MON_RESYNC_EN
              // Re-align to the received position without losing lock. No
              // wrap is reported even if this lands on position 0, since the
              // period was not completed in order.
              index_d = dec_idx;
`else
              // Treat the received code as the first sample of a new hunt.
              state_d     = HUNT;
              match_cnt_d = 3'd0;
              prev_idx_d  = dec_idx;
              prev_ok_d   = 1'b1;
`endif
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is small control state and is reset, so the
    // outputs are defined the moment rst_n falls, without waiting for a clock.
    if (!rst_n) begin
      state_q      <= HUNT;
      prev_idx_q   <= 3'd0;
      prev_ok_q    <= 1'b0;
      match_cnt_q  <= 3'd0;
      index_q      <= 3'd0;
      err_q        <= 1'b0;
      illegal_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_idx_q   <= prev_idx_d;
      prev_ok_q    <= prev_ok_d;
      match_cnt_q  <= match_cnt_d;
      index_q      <= index_d;
      err_q        <= err_d;
      illegal_q    <= illegal_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven straight from registers
  // ---------------------------------------------------------------------------
  assign locked        = (state_q == LOCKED);
  assign index_valid   = locked;
  assign index         = index_q;
  assign err_pulse     = err_q;
  assign illegal_pulse = illegal_q;
  assign wrap_pulse    = wrap_q;
  assign err_count     = err_count_q;
  assign wrap_count    = wrap_count_q;

endmodule
